// File: rtl/bus_write_sequencer.sv
// rtl/bus_write_sequencer.sv - line-to-byte burst writer onto an arbitrated shared 8-bit bus
//
// Captures a LINE_BYTES-wide line on start, requests the shared bus, and
// drives the line out one byte per granted cycle (byte 0 first) through an
// external tristate driver. A lost grant parks the burst in REQ and the
// same byte is re-driven once the grant returns. One-cycle done pulse at
// the end of the burst.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   line write request, sampled only in IDLE
//   line_data  in   line, byte k = bits [8k+7:8k]
//   busy       out  high in every state except IDLE
//   bus_req    out  request to the bus arbiter
//   bus_gnt    in   arbiter grant
//   drv_data   out  tristate driver data (8'h00 while not driving)
//   drv_en     out  tristate driver enable
//   done       out  one-cycle completion pulse

module bus_write_sequencer #(
    parameter int LINE_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [8*LINE_BYTES-1:0]   line_data,
    output logic                      busy,
    output logic                      bus_req,
    input  logic                      bus_gnt,
    output logic [7:0]                drv_data,
    output logic                      drv_en,
    output logic                      done
);

    localparam int IW = $clog2(LINE_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [7:0]    line_buf [LINE_BYTES];
    logic [IW-1:0] idx_inc;

    assign idx_inc = idx + IW'(1);

    // Outputs are registered alongside the state: every transition loads the
    // output values that belong to the state being entered, so drv_data
    // already holds the byte to be driven on the first cycle of DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            bus_req  <= 1'b0;
            drv_en   <= 1'b0;
            drv_data <= 8'h00;
            done     <= 1'b0;
            for (int k = 0; k < LINE_BYTES; k++) begin
                line_buf[k] <= 8'h00;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < LINE_BYTES; k++) begin
                            line_buf[k] <= line_data[8*k +: 8];
                        end
                        idx     <= '0;
                        state   <= REQ;
                        busy    <= 1'b1;
                        bus_req <= 1'b1;
                    end
                end

                REQ: begin
                    if (bus_gnt) begin
                        state    <= DRIVE;
                        drv_en   <= 1'b1;
                        drv_data <= line_buf[idx];
                    end
                end

                DRIVE: begin
                    if (bus_gnt) begin
                        // Byte at idx was accepted on this edge.
                        if (idx == LAST_IDX) begin
                            state    <= TURN;
                            bus_req  <= 1'b0;
                            drv_en   <= 1'b0;
                            drv_data <= 8'h00;
                            done     <= 1'b1;
                        end else begin
                            idx      <= idx_inc;
                            drv_data <= line_buf[idx_inc];
                        end
                    end else begin
                        // Grant lost: keep idx so the same byte goes out again.
                        state    <= REQ;
                        drv_en   <= 1'b0;
                        drv_data <= 8'h00;
                    end
                end

                TURN: begin
                    // Bus turnaround; start is deliberately not looked at here.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    bus_req  <= 1'b0;
                    drv_en   <= 1'b0;
                    drv_data <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_write_sequencer.sv
// tb/tb_bus_write_sequencer.sv - directed self-checking bench for bus_write_sequencer

module tb_bus_write_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] line_data;
    logic        busy;
    logic        bus_req;
    logic        bus_gnt;
    logic [7:0]  drv_data;
    logic        drv_en;
    logic        done;

    int checks;
    int errors;

    bus_write_sequencer #(.LINE_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .line_data (line_data),
        .busy      (busy),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .drv_data  (drv_data),
        .drv_en    (drv_en),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {busy, bus_req, drv_en, done, drv_data}.
    task automatic expect_out(input string tag, input logic b, input logic r,
                              input logic e, input logic d, input logic [7:0] data);
        check(tag, {20'h0, busy, bus_req, drv_en, done, drv_data},
                   {20'h0, b, r, e, d, data});
    endtask

    // Advance one clock; leaves us at the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic expect_req(input string tag);
        expect_out(tag, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic expect_drive(input string tag, input logic [7:0] data);
        expect_out(tag, 1'b1, 1'b1, 1'b1, 1'b0, data);
    endtask

    task automatic expect_turn(input string tag);
        expect_out(tag, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    // Full burst with grant tied high; line_data is scrambled after capture.
    task automatic burst_hi(input string tag, input logic [31:0] line);
        bus_gnt   = 1'b1;
        start     = 1'b1;
        line_data = line;
        step();
        start     = 1'b0;
        line_data = 32'h5A5A5A5A;
        expect_req({tag, "_req"});
        for (int k = 0; k < 4; k++) begin
            step();
            expect_drive($sformatf("%s_b%0d", tag, k), line[8*k +: 8]);
        end
        step();
        expect_turn({tag, "_turn"});
        step();
        expect_idle({tag, "_idle"});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        bus_gnt   = 1'b0;
        line_data = 32'h0;
        #1;
        expect_idle("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: outputs stay low, bus released.
        for (int i = 0; i < 5; i++) begin
            step();
            expect_idle($sformatf("idle%0d", i));
        end

        // Basic burst with grant tied high.
        burst_hi("basic", 32'hDDCCBBAA);

        // Grant withheld for 3 cycles after bus_req rises.
        bus_gnt   = 1'b0;
        start     = 1'b1;
        line_data = 32'hDDCCBBAA;
        step();
        start = 1'b0;
        expect_req("wait_r0");
        step();
        expect_req("wait_r1");
        step();
        expect_req("wait_r2");
        bus_gnt = 1'b1;
        step();
        expect_drive("wait_aa", 8'hAA);
        step();
        expect_drive("wait_bb", 8'hBB);
        step();
        expect_drive("wait_cc", 8'hCC);
        step();
        expect_drive("wait_dd", 8'hDD);
        step();
        expect_turn("wait_turn");
        step();
        expect_idle("wait_idle");

        // Grant lost after AA,BB transferred; CC re-driven after re-grant.
        bus_gnt   = 1'b1;
        start     = 1'b1;
        line_data = 32'hDDCCBBAA;
        step();
        start = 1'b0;
        expect_req("drop_req");
        step();
        expect_drive("drop_aa", 8'hAA);
        step();
        expect_drive("drop_bb", 8'hBB);
        step();
        expect_drive("drop_cc0", 8'hCC);
        bus_gnt = 1'b0;
        step();
        expect_req("drop_r0");
        step();
        expect_req("drop_r1");
        bus_gnt = 1'b1;
        step();
        expect_drive("drop_cc1", 8'hCC);
        step();
        expect_drive("drop_dd", 8'hDD);
        step();
        expect_turn("drop_turn");
        step();
        expect_idle("drop_idle");

        // start mid-burst ignored; start held through TURN is not taken
        // there but is taken in the following IDLE with the new line.
        bus_gnt   = 1'b1;
        start     = 1'b1;
        line_data = 32'hDDCCBBAA;
        step();
        start = 1'b0;
        expect_req("ign_req");
        step();
        expect_drive("ign_aa", 8'hAA);
        start     = 1'b1;
        line_data = 32'h44332211;
        step();
        start = 1'b0;
        expect_drive("ign_bb", 8'hBB);
        step();
        expect_drive("ign_cc", 8'hCC);
        step();
        expect_drive("ign_dd", 8'hDD);
        step();
        expect_turn("ign_turn");
        start = 1'b1;
        step();
        expect_idle("ign_idle");
        step();
        start     = 1'b0;
        line_data = 32'h0;
        expect_req("new_req");
        step();
        expect_drive("new_11", 8'h11);
        step();
        expect_drive("new_22", 8'h22);
        step();
        expect_drive("new_33", 8'h33);
        step();
        expect_drive("new_44", 8'h44);
        step();
        expect_turn("new_turn");
        step();
        expect_idle("new_idle");

        // Reset pulsed mid-DRIVE of BB: bus released at once, no done.
        bus_gnt   = 1'b1;
        start     = 1'b1;
        line_data = 32'hDDCCBBAA;
        step();
        start = 1'b0;
        expect_req("rst_req");
        step();
        expect_drive("rst_aa", 8'hAA);
        step();
        expect_drive("rst_bb", 8'hBB);
        #1;
        rst_n = 1'b0;
        #1;
        expect_idle("rst_async");
        step();
        expect_idle("rst_held");
        rst_n = 1'b1;
        step();
        expect_idle("rst_after");
        step();
        expect_idle("rst_after2");
        burst_hi("post", 32'hDDCCBBAA);

        // start presented at the same moment reset releases is taken on the next edge.
        rst_n = 1'b0;
        #1;
        expect_idle("rel_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        start     = 1'b1;
        line_data = 32'h0000BEEF;
        step();
        start = 1'b0;
        expect_req("rel_req");
        step();
        expect_drive("rel_ef", 8'hEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_write_sequencer.md
BUS_WRITE_SEQUENCER -- requirements
Module: bus_write_sequencer

Interface
REQ-001 Parameter LINE_BYTES, default 4, SHALL set bytes per burst; legal range 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request a line write; sampled only in IDLE.
REQ-005 line_data  input  8*LINE_BYTES  SHALL carry the line; byte k = bits [8k+7:8k].
REQ-006 busy  output  1  SHALL be high in every state except IDLE.
REQ-007 bus_req  output  1  SHALL request the shared 8-bit bus from the arbiter.
REQ-008 bus_gnt  input  1  SHALL be the arbiter grant.
REQ-009 drv_data  output  8  SHALL feed the tristate driver data input.
REQ-010 drv_en  output  1  SHALL feed the tristate driver enable.
REQ-011 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, REQ, DRIVE, TURN; all outputs registered or decoded from registered state only.
REQ-013 IDLE: start=1 at an edge SHALL capture line_data into an internal buffer, clear byte index to 0, and enter REQ.
REQ-014 start while busy=1 SHALL be ignored; line_data changes after capture SHALL not affect the burst.
REQ-015 REQ: bus_req=1, drv_en=0; bus_gnt=1 at an edge SHALL enter DRIVE; otherwise remain in REQ indefinitely.
REQ-016 DRIVE: bus_req=1, drv_en=1, drv_data = buffer byte[index], byte 0 first.
REQ-017 DRIVE with bus_gnt=1 at an edge SHALL count the byte transferred and increment index; after byte LINE_BYTES-1 SHALL enter TURN.
REQ-018 DRIVE with bus_gnt=0 at an edge SHALL return to REQ with index unchanged; the same byte is re-driven after re-grant.
REQ-019 TURN: drv_en=0, bus_req=0, done=1 for exactly one cycle, then IDLE; start SHALL not be accepted in TURN.
REQ-020 drv_data SHALL be 8'h00 whenever drv_en=0.
REQ-021 Index SHALL be $clog2(LINE_BYTES) bits wide and never exceed LINE_BYTES-1.
REQ-022 Minimum latency with bus_gnt held high: start edge -> REQ 1 cycle -> DRIVE LINE_BYTES cycles -> TURN 1 cycle; done asserted LINE_BYTES+1 cycles after REQ entry.
REQ-023 drv_en SHALL never be high in the same cycle as bus_req=0 (no bus drive without request).

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, index 0, buffer 0, and busy, bus_req, drv_en, done, drv_data all 0, independent of clk.
REQ-025 Reset asserted mid-burst SHALL release the bus asynchronously and discard the burst; no done pulse.
REQ-026 After rst_n rises, first start SHALL be accepted at the next rising edge.

Verification (LINE_BYTES=4)
REQ-027 Reset, then idle 5 cycles -> all outputs 0; downstream tristate out = 8'bz.
REQ-028 start with line_data=32'hDDCCBBAA, bus_gnt tied 1 -> bus_req next cycle; drv_en=1 with drv_data AA,BB,CC,DD on 4 consecutive cycles; done one cycle after DD; busy=0 after.
REQ-029 bus_gnt held 0 for 3 cycles after bus_req rises -> drv_en=0, drv_data=00 throughout; first AA on the cycle after bus_gnt rises.
REQ-030 bus_gnt drops after AA,BB transferred, low 2 cycles -> drv_en=0 in REQ; resumes driving CC then DD; done once.
REQ-031 start pulsed mid-burst with line_data=32'h44332211 -> ignored; burst completes AA..DD; only one done.
REQ-032 rst_n pulsed low during DRIVE of BB -> drv_en, bus_req 0 before next clk edge; no done; IDLE after release; new start behaves as REQ-028.
